// File: rtl/dns_filter_engine.sv
// dns_filter_engine: inline DNS-reflection filter for the 10G RX path.
// Parses DNS responses (suspect) and ICMP port-unreachable frames carrying an
// inner UDP header (filter), issues one lookup per matching frame, and drops
// whole frames whose lookup answers "arrest" while the frame sits in a
// fixed DELAY_DEPTH-cycle delay line.
// Optional: define DNS_FILTER_STATS_EN to build the pkt_cnt/drop_cnt counters;
// without it both read as constant 0.
module dns_filter_engine #(
  parameter int KEY_SIZE    = 96,
  parameter int DNS_PORT    = 53,
  parameter int DELAY_DEPTH = 32
) (
  input  logic                clk156,
  input  logic                eth_rst_n,
  input  logic                s_axis_tvalid,
  input  logic [63:0]         s_axis_tdata,
  input  logic [7:0]          s_axis_tkeep,
  input  logic                s_axis_tlast,
  input  logic                s_axis_tuser,
  output logic                m_axis_tvalid,
  output logic [63:0]         m_axis_tdata,
  output logic [7:0]          m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic                m_axis_tuser,
  output logic [KEY_SIZE-1:0] in_key,
  output logic [3:0]          in_flag,
  output logic                in_valid,
  input  logic                out_valid,
  input  logic [3:0]          out_flag,
  output logic [31:0]         pkt_cnt,
  output logic [31:0]         drop_cnt
);

  localparam int          PW        = $clog2(DELAY_DEPTH);
  localparam int          BW        = 75;  // valid + data + keep + last + user
  localparam logic [9:0]  LAST_SLOT = 10'(DELAY_DEPTH - 1);
  localparam logic [15:0] DNS_PORT_W = 16'(DNS_PORT);

  // Byte n of a beat lives on tdata[8n+7:8n]; multi-byte fields are big-endian.
  function automatic logic [7:0] lane(input logic [63:0] d, input int n);
    return d[8*n +: 8];
  endfunction

  // Only the arrest encoding out_flag[2:1] is meaningful here.
  logic unused_flag_bits;
  assign unused_flag_bits = out_flag[3] ^ out_flag[0];

  // ---------------- parser ----------------
  logic [9:0]  bc;
  logic [15:0] ethertype;
  logic [7:0]  ihl, proto, inner_proto;
  logic [31:0] src_ip, dst_ip, l4, inner_src, inner_dst;

  // Beat counter: saturating, restarts at 0 after every tlast.
  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      bc <= '0;
    end else if (s_axis_tvalid) begin
      if (s_axis_tlast)        bc <= '0;
      else if (bc != 10'd1023) bc <= bc + 10'd1;
    end
  end

  // Header field capture at fixed beat positions.
  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      ethertype   <= '0;
      ihl         <= '0;
      proto       <= '0;
      inner_proto <= '0;
      src_ip      <= '0;
      dst_ip      <= '0;
      l4          <= '0;
      inner_src   <= '0;
      inner_dst   <= '0;
    end else if (s_axis_tvalid) begin
      case (bc)
        10'd1: begin
          ethertype <= {lane(s_axis_tdata, 4), lane(s_axis_tdata, 5)};
          ihl       <= lane(s_axis_tdata, 6);
        end
        10'd2: proto <= lane(s_axis_tdata, 7);
        10'd3: begin
          src_ip        <= {lane(s_axis_tdata, 2), lane(s_axis_tdata, 3),
                            lane(s_axis_tdata, 4), lane(s_axis_tdata, 5)};
          dst_ip[31:16] <= {lane(s_axis_tdata, 6), lane(s_axis_tdata, 7)};
        end
        10'd4: begin
          dst_ip[15:0] <= {lane(s_axis_tdata, 0), lane(s_axis_tdata, 1)};
          l4           <= {lane(s_axis_tdata, 2), lane(s_axis_tdata, 3),
                           lane(s_axis_tdata, 4), lane(s_axis_tdata, 5)};
        end
        10'd6: begin
          inner_proto      <= lane(s_axis_tdata, 3);
          inner_src[31:16] <= {lane(s_axis_tdata, 6), lane(s_axis_tdata, 7)};
        end
        10'd7: begin
          inner_src[15:0] <= {lane(s_axis_tdata, 0), lane(s_axis_tdata, 1)};
          inner_dst       <= {lane(s_axis_tdata, 2), lane(s_axis_tdata, 3),
                              lane(s_axis_tdata, 4), lane(s_axis_tdata, 5)};
        end
        default: ;
      endcase
    end
  end

  // ---------------- lookup request ----------------
  logic                qual, fire_suspect, fire_filter, fire;
  logic [KEY_SIZE-1:0] key_next;

  assign qual         = (ethertype == 16'h0800) && (ihl == 8'h45);
  // Suspect: UDP from the DNS server port with QR (byte 44 bit 7) set.
  assign fire_suspect = s_axis_tvalid && (bc == 10'd5) && qual && (proto == 8'd17) &&
                        (l4[31:16] == DNS_PORT_W) && s_axis_tdata[39];
  // Filter: ICMP type 3 code 3 quoting a UDP datagram.
  assign fire_filter  = s_axis_tvalid && (bc == 10'd8) && qual && (proto == 8'd1) &&
                        (l4[31:16] == 16'h0303) && (inner_proto == 8'd17);
  assign fire         = fire_suspect || fire_filter;

  // Key is left-justified; the low KEY_SIZE-80 bits are zero padding.
  always_comb begin
    key_next = '0;
    if (fire_filter)
      key_next[KEY_SIZE-1 -: 80] = {inner_src, inner_dst,
                                    lane(s_axis_tdata, 0), lane(s_axis_tdata, 1)};
    else
      key_next[KEY_SIZE-1 -: 80] = {src_ip, dst_ip, l4[15:0]};
  end

  // Register the one-cycle lookup strobe with its key and opcode.
  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      in_valid <= 1'b0;
      in_key   <= '0;
      in_flag  <= '0;
    end else begin
      in_valid <= fire;
      if (fire) begin
        in_key  <= key_next;
        in_flag <= fire_filter ? 4'b0101 : 4'b0011;
      end
    end
  end

  // ---------------- verdict slot ----------------
  logic first, slot_open, slot_active, issued, arrest, drop_acc, drop_cur, close;

  assign first       = s_axis_tvalid && (bc == 10'd0);
  assign slot_active = first || slot_open;
  // issued may be stale from the previous frame on its first beat.
  assign arrest      = out_valid && (out_flag[2:1] == 2'b10) && issued && !first && slot_active;
  assign drop_cur    = (first ? 1'b0 : drop_acc) | arrest;
  assign close       = slot_active && s_axis_tvalid && (s_axis_tlast || bc == LAST_SLOT);

  // Track slot lifetime, lookup-issued status and the accumulated drop bit.
  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      slot_open <= 1'b0;
      issued    <= 1'b0;
      drop_acc  <= 1'b0;
    end else begin
      slot_open <= slot_active && !close;
      drop_acc  <= drop_cur;
      if (fire)       issued <= 1'b1;
      else if (first) issued <= 1'b0;
    end
  end

  // ---------------- delay line and verdict FIFO ----------------
  logic [BW-1:0]          dline [DELAY_DEPTH];
  logic [BW-1:0]          stage_in;
  logic [DELAY_DEPTH-1:0] vfifo;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic                   d_valid, d_last, first_out, out_in_frame, drop_lat, drop_now;

  assign stage_in = {s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser};

  // Fixed-latency shift register, idle cycles included.
  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      for (int i = 0; i < DELAY_DEPTH; i++) dline[i] <= '0;
    end else begin
      dline[0] <= stage_in;
      for (int i = 1; i < DELAY_DEPTH; i++) dline[i] <= dline[i-1];
    end
  end

  assign d_valid   = dline[DELAY_DEPTH-1][74];
  assign d_last    = dline[DELAY_DEPTH-1][1];
  assign first_out = d_valid && !out_in_frame;
  assign drop_now  = first_out ? vfifo[rd_ptr] : drop_lat;

  // Verdict FIFO: push on slot close, pop on each frame's first output beat.
  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      vfifo  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (close) begin
        vfifo[wr_ptr] <= drop_cur;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (first_out) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Hold the popped verdict for the rest of the outgoing frame.
  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      out_in_frame <= 1'b0;
      drop_lat     <= 1'b0;
    end else begin
      if (d_valid)   out_in_frame <= !d_last;
      if (first_out) drop_lat     <= vfifo[rd_ptr];
    end
  end

  assign m_axis_tvalid = d_valid && !drop_now;
  assign m_axis_tdata  = dline[DELAY_DEPTH-1][73:10];
  assign m_axis_tkeep  = dline[DELAY_DEPTH-1][9:2];
  assign m_axis_tlast  = d_last && !drop_now;
  assign m_axis_tuser  = dline[DELAY_DEPTH-1][0];

`ifdef DNS_FILTER_STATS_EN
  // Count frames as their last beat leaves the delay line.
  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else if (d_valid && d_last) begin
      if (drop_now) drop_cnt <= drop_cnt + 32'd1;
      else          pkt_cnt  <= pkt_cnt + 32'd1;
    end
  end
`else
  assign pkt_cnt  = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_dns_filter_engine.sv
// tb_dns_filter_engine: builds a cycle timeline of frames and lookup
// responses, derives the expected filtered stream and lookups from frame
// bytes, then drives the timeline and compares every cycle.
module tb_dns_filter_engine;
  localparam int KS   = 96;
  localparam int DD   = 32;
  localparam int N    = 2048;
  localparam int MAXF = 256;

  logic          clk156 = 1'b0;
  logic          eth_rst_n;
  logic          s_axis_tvalid, s_axis_tlast, s_axis_tuser;
  logic [63:0]   s_axis_tdata;
  logic [7:0]    s_axis_tkeep;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic [63:0]   m_axis_tdata;
  logic [7:0]    m_axis_tkeep;
  logic [KS-1:0] in_key;
  logic [3:0]    in_flag;
  logic          in_valid;
  logic          out_valid;
  logic [3:0]    out_flag;
  logic [31:0]   pkt_cnt, drop_cnt;

  always #5 clk156 = ~clk156;

  dns_filter_engine #(.KEY_SIZE(KS), .DNS_PORT(53), .DELAY_DEPTH(DD)) dut (
    .clk156(clk156), .eth_rst_n(eth_rst_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .in_key(in_key), .in_flag(in_flag), .in_valid(in_valid),
    .out_valid(out_valid), .out_flag(out_flag),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  int errors = 0;
  int checks = 0;
  int exp_pkt = 0;
  int exp_drop = 0;

  // Timeline, indexed by cycle.
  logic          iv [N];
  logic [63:0]   idata [N];
  logic [7:0]    ikeep [N];
  logic          ilast [N];
  logic          iuser [N];
  logic          rv [N];
  logic [3:0]    rf [N];
  logic          lv [N];
  logic [KS-1:0] lkey [N];
  logic [3:0]    lflag [N];
  int            fid [N];
  // Per-frame facts.
  int   nf;
  int   fw0 [MAXF];
  int   fclose [MAXF];
  int   fL [MAXF];
  logic fdrop [MAXF];
  int   wptr;
  logic [7:0] fb [512];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_tl();
    for (int c = 0; c < N; c++) begin
      iv[c] = 0; idata[c] = '0; ikeep[c] = '0; ilast[c] = 0; iuser[c] = 0;
      rv[c] = 0; rf[c] = '0; lv[c] = 0; lkey[c] = '0; lflag[c] = '0; fid[c] = -1;
    end
    nf = 0;
    wptr = 0;
  endtask

  // kind: 0 DNS resp, 1 DNS query, 2 ICMP 3/3 inner UDP, 3 ICMP inner TCP,
  //       4 bad ethertype, 5 bad IHL, 6 random bytes.
  // resp_mode: 0 none, 1 at lookup+arg, 2 at beat arg, 3 at first beat+arg.
  task automatic add_frame(input int kind, input int nb, input int gap_pct,
                           input int resp_mode, input int arg,
                           input logic [3:0] rflag, input int post_gap);
    int f, r;
    int bw [64];
    logic qual;
    f = nf;
    nf++;
    for (int i = 0; i < 512; i++) fb[i] = 8'($urandom);
    if (kind <= 5) begin
      fb[12] = 8'h08; fb[13] = 8'h00; fb[14] = 8'h45;
    end
    if (kind == 0 || kind == 1 || kind == 4 || kind == 5) begin
      fb[23] = 8'd17; fb[34] = 8'd0; fb[35] = 8'd53;
      fb[44][7] = (kind != 1);
      if (kind == 4) fb[13] = 8'h06;
      if (kind == 5) fb[14] = 8'h46;
    end else if (kind == 2 || kind == 3) begin
      fb[23] = 8'd1; fb[34] = 8'd3; fb[35] = 8'd3;
      fb[51] = (kind == 2) ? 8'd17 : 8'd6;
      fb[64] = 8'd0; fb[65] = 8'd53;
    end
    for (int b = 0; b < nb; b++) begin
      if (b > 0 && $urandom_range(0, 99) < gap_pct) wptr += 1 + $urandom_range(0, 2);
      bw[b] = wptr;
      iv[wptr] = 1;
      for (int n = 0; n < 8; n++) idata[wptr][8*n +: 8] = fb[8*b + n];
      ikeep[wptr] = (b == nb - 1) ? 8'($urandom_range(1, 255)) : 8'hff;
      ilast[wptr] = (b == nb - 1);
      iuser[wptr] = 1'($urandom);
      fid[wptr] = f;
      wptr++;
    end
    fw0[f] = bw[0];
    fclose[f] = (nb > DD) ? bw[DD-1] : bw[nb-1];
    fL[f] = -1;
    qual = (fb[12] == 8'h08) && (fb[13] == 8'h00) && (fb[14] == 8'h45);
    if (qual && fb[23] == 8'd17 && {fb[34], fb[35]} == 16'd53 && fb[44][7] && nb > 5) begin
      fL[f] = bw[5] + 1;
      lkey[fL[f]] = {fb[26], fb[27], fb[28], fb[29], fb[30], fb[31], fb[32], fb[33],
                     fb[36], fb[37], 16'h0000};
      lflag[fL[f]] = 4'b0011;
    end else if (qual && fb[23] == 8'd1 && fb[34] == 8'd3 && fb[35] == 8'd3 &&
                 fb[51] == 8'd17 && nb > 8) begin
      fL[f] = bw[8] + 1;
      lkey[fL[f]] = {fb[54], fb[55], fb[56], fb[57], fb[58], fb[59], fb[60], fb[61],
                     fb[64], fb[65], 16'h0000};
      lflag[fL[f]] = 4'b0101;
    end
    if (fL[f] >= 0) lv[fL[f]] = 1;
    r = -1;
    if (resp_mode == 1 && fL[f] >= 0) r = fL[f] + arg;
    if (resp_mode == 2 && arg < nb)   r = bw[arg];
    if (resp_mode == 3)               r = bw[0] + arg;
    if (r >= 0) begin
      rv[r] = 1;
      rf[r] = rflag;
    end
    wptr += post_gap;
  endtask

  task automatic add_noise(input int from, input int upto, input int pct);
    for (int c = from; c < upto; c++)
      if ($urandom_range(0, 99) < pct) begin
        rv[c] = 1;
        rf[c] = 4'($urandom);
      end
  endtask

  // A frame is dropped iff an arrest reply lands after its lookup and
  // no later than the beat that closes its verdict window.
  task automatic finalize();
    for (int f = 0; f < nf; f++) if (fL[f] >= 0) rv[fL[f]] = 0;
    for (int f = 0; f < nf; f++) begin
      fdrop[f] = 0;
      if (fL[f] >= 0)
        for (int r = fL[f] + 1; r <= fclose[f]; r++)
          if (rv[r] && rf[r][2:1] == 2'b10) fdrop[f] = 1;
    end
  endtask

  task automatic run_tl(input int n);
    int src;
    logic dr, ev, el, eu;
    logic [63:0] ed;
    logic [7:0] ek;
    for (int c = 0; c < n; c++) begin
      @(negedge clk156);
      src = c - DD;
      dr = 0; ev = 0; el = 0; eu = 0; ed = '0; ek = '0;
      if (src >= 0) begin
        dr = (fid[src] >= 0) ? fdrop[fid[src]] : 1'b0;
        ev = iv[src] && !dr;
        el = ilast[src] && !dr;
        ed = idata[src];
        ek = ikeep[src];
        eu = iuser[src];
      end
      chk($sformatf("tvalid@%0d", c), 128'(m_axis_tvalid), 128'(ev));
      chk($sformatf("tlast@%0d", c), 128'(m_axis_tlast), 128'(el));
      chk($sformatf("tdata@%0d", c), 128'(m_axis_tdata), 128'(ed));
      chk($sformatf("tkeep@%0d", c), 128'(m_axis_tkeep), 128'(ek));
      chk($sformatf("tuser@%0d", c), 128'(m_axis_tuser), 128'(eu));
      chk($sformatf("in_valid@%0d", c), 128'(in_valid), 128'(lv[c]));
      if (lv[c]) begin
        chk($sformatf("in_key@%0d", c), 128'(in_key), 128'(lkey[c]));
        chk($sformatf("in_flag@%0d", c), 128'(in_flag), 128'(lflag[c]));
        $display("lookup @%0d flag=%b key=%h", c, lflag[c], lkey[c]);
      end
`ifdef DNS_FILTER_STATS_EN
      chk($sformatf("pkt_cnt@%0d", c), 128'(pkt_cnt), 128'(exp_pkt));
      chk($sformatf("drop_cnt@%0d", c), 128'(drop_cnt), 128'(exp_drop));
`else
      chk($sformatf("pkt_cnt@%0d", c), 128'(pkt_cnt), 128'(0));
      chk($sformatf("drop_cnt@%0d", c), 128'(drop_cnt), 128'(0));
`endif
      if (src >= 0 && iv[src] && ilast[src]) begin
        if (dr) exp_drop++;
        else    exp_pkt++;
        $display("frame %0d out @%0d: %s", fid[src], c, dr ? "dropped" : "forwarded");
      end
      s_axis_tvalid = iv[c];
      s_axis_tdata  = idata[c];
      s_axis_tkeep  = ikeep[c];
      s_axis_tlast  = ilast[c];
      s_axis_tuser  = iuser[c];
      out_valid     = rv[c];
      out_flag      = rf[c];
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "time limit");
  end

  initial begin
    int rand_start, kind, nb, mode, arg;
    logic [3:0] fl;
    eth_rst_n = 1'b0;
    s_axis_tvalid = 0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 0; s_axis_tuser = 0;
    out_valid = 0; out_flag = '0;
    #1;
    chk("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("rst_tlast", 128'(m_axis_tlast), 128'(0));
    chk("rst_tdata", 128'(m_axis_tdata), 128'(0));
    chk("rst_in_valid", 128'(in_valid), 128'(0));
    chk("rst_in_key", 128'(in_key), 128'(0));
    chk("rst_in_flag", 128'(in_flag), 128'(0));
    chk("rst_pkt_cnt", 128'(pkt_cnt), 128'(0));
    chk("rst_drop_cnt", 128'(drop_cnt), 128'(0));
    repeat (3) @(negedge clk156);
    eth_rst_n = 1'b1;

    // Directed scenarios followed by randomized traffic.
    clear_tl();
    add_frame(0, 10, 0, 0, 0, 4'b0000, 4);
    add_frame(0, 10, 0, 1, 2, 4'b0100, 4);
    add_frame(2, 12, 0, 2, 11, 4'b0100, 4);
    for (int i = 0; i < 64; i++) add_frame(6, 1, 0, 0, 0, 4'b0000, 0);
    add_frame(0, 10, 0, 1, 2, 4'b0100, 4);
    add_frame(0, 40, 0, 2, 35, 4'b0100, 4);
    add_frame(0, 12, 0, 1, 3, 4'b0110, 2);
    add_frame(0, 12, 0, 3, 2, 4'b0100, 2);
    rand_start = wptr;
    for (int i = 0; i < 40 && wptr < N - 200; i++) begin
      kind = $urandom_range(0, 6);
      nb   = $urandom_range(1, 45);
      mode = $urandom_range(0, 3);
      arg  = $urandom_range(1, 40);
      fl   = 4'($urandom);
      if ($urandom_range(0, 1) == 1) fl[2:1] = 2'b10;
      add_frame(kind, nb, ($urandom_range(0, 1) == 1) ? 10 : 0, mode, arg, fl,
                $urandom_range(0, 3));
    end
    add_noise(rand_start, wptr, 3);
    wptr += DD + 8;
    finalize();
    run_tl(wptr);

    // Long frame cut by reset while its head is already leaving.
    clear_tl();
    add_frame(6, 40, 0, 0, 0, 4'b0000, 0);
    finalize();
    run_tl(36);
    #2;
    eth_rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("midrst_tdata", 128'(m_axis_tdata), 128'(0));
    chk("midrst_tkeep", 128'(m_axis_tkeep), 128'(0));
    chk("midrst_tuser", 128'(m_axis_tuser), 128'(0));
    chk("midrst_pkt_cnt", 128'(pkt_cnt), 128'(0));
    chk("midrst_drop_cnt", 128'(drop_cnt), 128'(0));
    s_axis_tvalid = 0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 0; s_axis_tuser = 0;
    out_valid = 0; out_flag = '0;
    exp_pkt = 0;
    exp_drop = 0;
    repeat (2) @(negedge clk156);
    eth_rst_n = 1'b1;

    // Traffic after reset behaves normally.
    clear_tl();
    add_frame(0, 10, 0, 1, 3, 4'b0100, 2);
    add_frame(0, 10, 0, 0, 0, 4'b0000, 2);
    add_frame(2, 12, 20, 0, 0, 4'b0000, 2);
    add_frame(6, 3, 0, 0, 0, 4'b0000, 2);
    wptr += DD + 8;
    finalize();
    run_tl(wptr);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
